cache_line_fill_ctrl: RTL and testbench

CACHE_LINE_FILL_CTRL -- requirements
Module: cache_line_fill_ctrl

---
 rtl/cache_line_fill_ctrl_if.sv | 38 +++
 rtl/cache_line_fill_ctrl.sv | 131 +++++++++++++
 tb/tb_cache_line_fill_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_line_fill_ctrl_if.sv
// Bus bundle between the line-fill controller (master) and the cache/RAM side (slave).
interface cache_line_fill_ctrl_if #(
  parameter int TAG_W = 22
);
  logic             miss;
  logic             valid;
  logic             dirty;
  logic [TAG_W-1:0] tag;
  logic [31:0]      miss_addr;
  logic [31:0]      cache_rd_data;
  logic             ram_wr_done;
  logic             ram_rd_done;
  logic [31:0]      ram_rd_data;
  logic             ram_wr_start;
  logic             ram_rd_start;
  logic [31:0]      ram_wr_addr;
  logic [31:0]      ram_rd_addr;
  logic [31:0]      ram_wr_data;
  logic             cache_wr_en;
  logic [31:0]      cache_addr;
  logic [31:0]      cache_wr_data;
  logic             busy;
  logic             fill_done;

  modport master (
    input  miss, valid, dirty, tag, miss_addr, cache_rd_data,
           ram_wr_done, ram_rd_done, ram_rd_data,
    output ram_wr_start, ram_rd_start, ram_wr_addr, ram_rd_addr, ram_wr_data,
           cache_wr_en, cache_addr, cache_wr_data, busy, fill_done
  );

  modport slave (
    output miss, valid, dirty, tag, miss_addr, cache_rd_data,
           ram_wr_done, ram_rd_done, ram_rd_data,
    input  ram_wr_start, ram_rd_start, ram_wr_addr, ram_rd_addr, ram_wr_data,
           cache_wr_en, cache_addr, cache_wr_data, busy, fill_done
  );
endinterface

// File: rtl/cache_line_fill_ctrl.sv
// Cache line fill controller: optional victim write-back, then word-by-word line fill.
// Define CACHE_LINE_FILL_CTRL_DIRTY_EN to write back only dirty victims (default: any valid victim).
//
// state     | meaning
// IDLE      | waiting for a miss
// WB_REQ    | read victim word from cache, launch RAM write
// WB_WAIT   | wait for RAM write completion
// RD_REQ    | launch RAM read of current fill word
// RD_WAIT   | wait for RAM read completion
// UPDATE    | write fetched word into the cache
// DONE      | line complete, pulse fill_done
module cache_line_fill_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 22,
  parameter int RAM_W      = 16
) (
  input logic                    clk,
  input logic                    reset_n,
  cache_line_fill_ctrl_if.master bus
);
  localparam int CW    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int OFF_W = $clog2(LINE_WORDS) + 2;
  localparam int RSH   = $clog2(RAM_W / 8);
  localparam logic [31:0]   OFF_MASK = (32'd1 << OFF_W) - 32'd1;
  localparam logic [CW-1:0] LAST_CNT = CW'(LINE_WORDS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WB_REQ  = 3'd1;
  localparam logic [2:0] S_WB_WAIT = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_UPDATE  = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [31:0]      base;
  logic [TAG_W-1:0] tag_q;
  logic             wr_start_q;
  logic [31:0]      wr_addr_q;
  logic [31:0]      wr_data_q;
  logic [31:0]      fill_data_q;
  logic             need_wb;
  logic             last;
  logic [31:0]      fill_addr;
  logic [31:0]      victim_addr;

`ifdef CACHE_LINE_FILL_CTRL_DIRTY_EN
  assign need_wb = bus.valid & bus.dirty;
`else
  logic dirty_unused;
  assign dirty_unused = bus.dirty;
  assign need_wb      = bus.valid;
`endif

  assign last        = (cnt == LAST_CNT);
  assign fill_addr   = base | (32'(cnt) << 2);
  // Victim shares the index and word offset with the fill line; only the tag differs.
  assign victim_addr = {tag_q, fill_addr[31-TAG_W:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      base        <= '0;
      tag_q       <= '0;
      wr_start_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      fill_data_q <= '0;
    end else begin
      wr_start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.miss) begin
            base  <= bus.miss_addr & ~OFF_MASK;
            tag_q <= bus.tag;
            cnt   <= '0;
            state <= need_wb ? S_WB_REQ : S_RD_REQ;
          end
        end
        S_WB_REQ: begin
          // Start is registered so the RAM sees address, data and start together.
          wr_data_q  <= bus.cache_rd_data;
          wr_addr_q  <= victim_addr >> RSH;
          wr_start_q <= 1'b1;
          state      <= S_WB_WAIT;
        end
        S_WB_WAIT: begin
          if (bus.ram_wr_done) begin
            if (last) begin
              cnt   <= '0;
              state <= S_RD_REQ;
            end else begin
              cnt   <= cnt + CW'(1);
              state <= S_WB_REQ;
            end
          end
        end
        S_RD_REQ: state <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (bus.ram_rd_done) begin
            fill_data_q <= bus.ram_rd_data;
            state       <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (last) begin
            state <= S_DONE;
          end else begin
            cnt   <= cnt + CW'(1);
            state <= S_RD_REQ;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy          = (state != S_IDLE);
  assign bus.fill_done     = (state == S_DONE);
  assign bus.ram_rd_start  = (state == S_RD_REQ);
  assign bus.ram_rd_addr   = fill_addr >> RSH;
  assign bus.ram_wr_start  = wr_start_q;
  assign bus.ram_wr_addr   = wr_addr_q;
  assign bus.ram_wr_data   = wr_data_q;
  assign bus.cache_wr_en   = (state == S_UPDATE);
  assign bus.cache_wr_data = fill_data_q;
  assign bus.cache_addr    = (state == S_WB_REQ || state == S_WB_WAIT) ? victim_addr : fill_addr;
endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Scoreboard bench for cache_line_fill_ctrl: a line-level reference model queues the expected
// RAM/cache event stream; a monitor pops and compares whenever the DUT presents an event.
module tb_cache_line_fill_ctrl;
  localparam int LW    = 4;
  localparam int TAG_W = 22;
  localparam int RAM_W = 16;
  localparam int BPW   = RAM_W / 8;
  localparam int EV_WR = 0, EV_RD = 1, EV_CW = 2, EV_DONE = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic clk;
  logic reset_n;
  int n_chk = 0, n_pass = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, wr_cnt = 0, rd_cnt = 0;
  int rd_delay = 0, wr_delay = 0;
  int lat;
  logic [31:0] rsp_rd_addr;
  ev_t exp_q[$];

  cache_line_fill_ctrl_if #(.TAG_W(TAG_W)) bus ();

  cache_line_fill_ctrl #(.LINE_WORDS(LW), .TAG_W(TAG_W), .RAM_W(RAM_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  function automatic logic [31:0] cache_word(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ram_word(logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'h0000_0055;
  endfunction

  assign bus.cache_rd_data = cache_word(bus.cache_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: whole-line behaviour expressed as address arithmetic.
  task automatic push_txn(logic [31:0] a, logic v, logic d, logic [TAG_W-1:0] t);
    logic [31:0] line_bytes, base, span, vbase, wa, fa;
    bit need;
    line_bytes = 32'(LW * 4);
    base  = (a / line_bytes) * line_bytes;
    span  = 32'd1 << (32 - TAG_W);
    vbase = (32'(t) << (32 - TAG_W)) + (base % span);
`ifdef CACHE_LINE_FILL_CTRL_DIRTY_EN
    need = v && d;
`else
    need = v;
`endif
    if (need)
      for (int i = 0; i < LW; i++) begin
        wa = vbase + 32'(4 * i);
        exp_q.push_back('{EV_WR, wa / BPW, cache_word(wa)});
      end
    for (int i = 0; i < LW; i++) begin
      fa = base + 32'(4 * i);
      exp_q.push_back('{EV_RD, fa / BPW, 32'd0});
      exp_q.push_back('{EV_CW, fa, ram_word(fa / BPW)});
    end
    exp_q.push_back('{EV_DONE, 32'd0, 32'd0});
  endtask

  task automatic take(int kind, logic [31:0] a, logic [31:0] d);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL event: got kind %0d addr %h data %h, expected no event", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.addr === a && e.data === d) n_pass++;
      else $display("FAIL event: got kind %0d addr %h data %h, expected kind %0d addr %h data %h",
                    kind, a, d, e.kind, e.addr, e.data);
    end
  endtask

  // Monitor
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (bus.ram_wr_start) begin wr_cnt++; take(EV_WR, bus.ram_wr_addr, bus.ram_wr_data); end
      if (bus.ram_rd_start) begin rd_cnt++; take(EV_RD, bus.ram_rd_addr, 32'd0); end
      if (bus.cache_wr_en) take(EV_CW, bus.cache_addr, bus.cache_wr_data);
      if (bus.fill_done) begin done_cnt++; done_cyc = cyc; take(EV_DONE, 32'd0, 32'd0); end
    end
  end

  // RAM read responder
  initial forever begin
    @(negedge clk);
    if (reset_n && bus.ram_rd_start) begin
      rsp_rd_addr = bus.ram_rd_addr;
      repeat (rd_delay) @(posedge clk);
      @(posedge clk); #1;
      bus.ram_rd_done = 1'b1;
      bus.ram_rd_data = ram_word(rsp_rd_addr);
      @(posedge clk); #1;
      bus.ram_rd_done = 1'b0;
    end
  end

  // RAM write responder
  initial forever begin
    @(negedge clk);
    if (reset_n && bus.ram_wr_start) begin
      repeat (wr_delay) @(posedge clk);
      @(posedge clk); #1;
      bus.ram_wr_done = 1'b1;
      @(posedge clk); #1;
      bus.ram_wr_done = 1'b0;
    end
  end

  task automatic wait_done(int target);
    for (int i = 0; i < 600 && done_cnt < target; i++) begin
      @(negedge clk); #1;
    end
    chk("done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic run_txn(input logic [31:0] a, input logic v, input logic d,
                         input logic [TAG_W-1:0] t, input int hold, output int latency);
    int target, c0;
    target = done_cnt + 1;
    push_txn(a, v, d, t);
    @(posedge clk); #1;
    bus.miss = 1'b1; bus.miss_addr = a; bus.valid = v; bus.dirty = d; bus.tag = t;
    c0 = cyc;
    repeat (hold + 1) begin
      @(posedge clk); #1;
      bus.miss_addr = $urandom;
    end
    bus.miss = 1'b0;
    wait_done(target);
    latency = done_cyc - c0 + 1;
  endtask

  task automatic reset_checks(string p);
    chk({p, "_busy"}, 32'(bus.busy), 32'd0);
    chk({p, "_fill_done"}, 32'(bus.fill_done), 32'd0);
    chk({p, "_cache_wr_en"}, 32'(bus.cache_wr_en), 32'd0);
    chk({p, "_ram_wr_start"}, 32'(bus.ram_wr_start), 32'd0);
    chk({p, "_ram_rd_start"}, 32'(bus.ram_rd_start), 32'd0);
    chk({p, "_cache_addr"}, bus.cache_addr, 32'd0);
    chk({p, "_ram_rd_addr"}, bus.ram_rd_addr, 32'd0);
    chk({p, "_ram_wr_addr"}, bus.ram_wr_addr, 32'd0);
    chk({p, "_ram_wr_data"}, bus.ram_wr_data, 32'd0);
    chk({p, "_cache_wr_data"}, bus.cache_wr_data, 32'd0);
  endtask

  task automatic spur_rd_done();
    int w0 = wr_cnt;
    for (int i = 0; i < 200 && wr_cnt == w0; i++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    bus.ram_rd_done = 1'b1; bus.ram_rd_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.ram_rd_done = 1'b0;
  endtask

  task automatic spur_wr_done();
    int r0 = rd_cnt;
    for (int i = 0; i < 300 && rd_cnt == r0; i++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    bus.ram_wr_done = 1'b1;
    @(posedge clk); #1;
    bus.ram_wr_done = 1'b0;
  endtask

  initial begin
    int r0, r1, tgt;
    bus.miss = 0; bus.valid = 0; bus.dirty = 0; bus.tag = '0; bus.miss_addr = '0;
    bus.ram_wr_done = 0; bus.ram_rd_done = 0; bus.ram_rd_data = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    reset_n = 1'b1;

    // Clean miss, single-cycle RAM: minimum latency
    run_txn(32'h0000_0124, 1'b0, 1'b0, '0, 0, lat);
    chk("latency_min", 32'(lat), 32'(3 * LW + 2));

    run_txn(32'h0000_0040, 1'b1, 1'b1, 22'h3, 0, lat);
    run_txn(32'h0000_5A7C, 1'b1, 1'b0, 22'h2AB, 2, lat);

    // Slow RAM reads
    rd_delay = 5;
    r0 = rd_cnt;
    run_txn(32'h0001_2348, 1'b0, 1'b0, '0, 1, lat);
    chk("slow_rd_starts", 32'(rd_cnt - r0), 32'(LW));
    rd_delay = 0;

    // Done pulses outside their own WAIT state
    wr_delay = 4; rd_delay = 4;
    fork
      run_txn(32'h1000_0080, 1'b1, 1'b1, 22'h1F00F, 0, lat);
      spur_rd_done();
      spur_wr_done();
    join
    wr_delay = 0; rd_delay = 0;

    // Miss held high across DONE is accepted again
    tgt = done_cnt + 1;
    push_txn(32'h0000_0A00, 1'b0, 1'b0, '0);
    push_txn(32'h0000_0B30, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    bus.miss = 1'b1; bus.miss_addr = 32'h0000_0A00; bus.valid = 1'b0;
    @(posedge clk); #1;
    bus.miss_addr = 32'h0000_0B30;
    wait_done(tgt);
    @(posedge clk); #1;
    chk("b2b_idle_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    bus.miss = 1'b0;
    chk("b2b_accept_busy", 32'(bus.busy), 32'd1);
    wait_done(tgt + 1);

    // Reset during the second RD_WAIT, then restart from word 0
    rd_delay = 3;
    push_txn(32'h0000_0300, 1'b0, 1'b0, '0);
    r1 = rd_cnt;
    @(posedge clk); #1;
    bus.miss = 1'b1; bus.miss_addr = 32'h0000_0300; bus.valid = 1'b0;
    @(posedge clk); #1;
    bus.miss = 1'b0;
    for (int i = 0; i < 100 && rd_cnt < r1 + 2; i++) begin @(negedge clk); #1; end
    chk("mid_rd_reached", 32'(rd_cnt - r1), 32'd2);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    reset_checks("mid_rst");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) @(posedge clk);
    rd_delay = 0;
    run_txn(32'h0000_0300, 1'b0, 1'b0, '0, 0, lat);
    chk("post_rst_latency", 32'(lat), 32'(3 * LW + 2));

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      rd_delay = $urandom_range(0, 3);
      wr_delay = $urandom_range(0, 3);
      run_txn($urandom, 1'($urandom), 1'($urandom), TAG_W'($urandom), $urandom_range(0, 4), lat);
    end

    repeat (5) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
